// File: rtl/filtered_ram_swap_control.sv
// Double-buffered projection store: the filter fills one bank while the
// processing side reads the other, with banks swapped by a request/ack handshake.
module filtered_ram_swap_control #(
    parameter int unsigned ANGLE_W    = 8,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned S_W        = 9,
    parameter int unsigned PROJ_LEN   = 256,
    parameter int unsigned NUM_ANGLES = 180
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               fl_valid,
    output logic               fl_ready,
    input  logic [ANGLE_W-1:0] fl_angle,
    input  logic [DATA_W-1:0]  fl_val,
    input  logic               fr_next_angle,
    output logic               fr_next_angle_ack,
    output logic               fr_has_next_angle,
    output logic [ANGLE_W-1:0] fr_angle,
    input  logic [S_W-1:0]     fr0_s_val,
    input  logic [S_W-1:0]     fr1_s_val,
    output logic [DATA_W-1:0]  fr0_val,
    output logic [DATA_W-1:0]  fr1_val
);

    localparam int unsigned AW = $clog2(PROJ_LEN);
    localparam int unsigned CW = $clog2(NUM_ANGLES + 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_st_t;

    bank_st_t           r_st        [2];
    logic [ANGLE_W-1:0] r_angle_reg [2];
    logic [CW-1:0]      r_wr_cnt;
    logic [CW-1:0]      r_hand_cnt;
    logic [AW-1:0]      r_wr_addr;
    logic               r_rd_sel;
    logic [DATA_W-1:0]  r_mem0 [PROJ_LEN];
    logic [DATA_W-1:0]  r_mem1 [PROJ_LEN];

    logic              w_wr_bank;
    logic              w_hand_bank;
    logic              w_wr_en;
    logic              w_in0;
    logic              w_in1;
    logic [AW-1:0]     w_addr0;
    logic [AW-1:0]     w_addr1;
    logic [DATA_W-1:0] w_rd0;
    logic [DATA_W-1:0] w_rd1;

    // Signed offset is in range when non-negative and below PROJ_LEN.
    function automatic logic in_range(input logic [S_W-1:0] s);
        return !s[S_W-1] && (int'(s[S_W-2:0]) < int'(PROJ_LEN));
    endfunction

    assign w_wr_bank   = r_wr_cnt[0];
    assign w_hand_bank = r_hand_cnt[0];

    assign fl_ready = reset_n && !frame_start && (r_wr_cnt < CW'(NUM_ANGLES)) &&
                      (r_st[w_wr_bank] == EMPTY || r_st[w_wr_bank] == FILLING);
    assign w_wr_en  = fl_valid && fl_ready;

    assign fr_next_angle_ack = reset_n && !frame_start && fr_next_angle &&
                               (r_hand_cnt < CW'(NUM_ANGLES)) && (r_st[w_hand_bank] == FULL);
    assign fr_has_next_angle = (r_hand_cnt != CW'(NUM_ANGLES));

    assign w_in0   = in_range(fr0_s_val);
    assign w_in1   = in_range(fr1_s_val);
    assign w_addr0 = fr0_s_val[AW-1:0];
    assign w_addr1 = fr1_s_val[AW-1:0];
    assign w_rd0   = r_rd_sel ? r_mem1[w_addr0] : r_mem0[w_addr0];
    assign w_rd1   = r_rd_sel ? r_mem1[w_addr1] : r_mem0[w_addr1];

    // Sample storage; contents survive reset and frame_start.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            if (w_wr_bank) r_mem1[r_wr_addr] <= fl_val;
            else           r_mem0[r_wr_addr] <= fl_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_st[0]        <= EMPTY;
            r_st[1]        <= EMPTY;
            r_angle_reg[0] <= '0;
            r_angle_reg[1] <= '0;
            r_wr_cnt       <= '0;
            r_hand_cnt     <= '0;
            r_wr_addr      <= '0;
            r_rd_sel       <= 1'b0;
            fr_angle       <= '0;
            fr0_val        <= '0;
            fr1_val        <= '0;
        end else begin
            fr0_val <= w_in0 ? w_rd0 : '0;
            fr1_val <= w_in1 ? w_rd1 : '0;
            if (frame_start) begin
                // Discard every bank, including a partial fill; fr_angle holds.
                r_st[0]    <= EMPTY;
                r_st[1]    <= EMPTY;
                r_wr_cnt   <= '0;
                r_hand_cnt <= '0;
                r_wr_addr  <= '0;
            end else begin
                if (w_wr_en) begin
                    if (r_wr_addr == '0) begin
                        r_st[w_wr_bank]        <= FILLING;
                        r_angle_reg[w_wr_bank] <= fl_angle;
                    end
                    if (r_wr_addr == AW'(PROJ_LEN - 1)) begin
                        r_st[w_wr_bank] <= FULL;
                        r_wr_cnt        <= r_wr_cnt + CW'(1);
                        r_wr_addr       <= '0;
                    end else begin
                        r_wr_addr <= r_wr_addr + AW'(1);
                    end
                end
                // Ack bank is FULL and the write bank is EMPTY/FILLING, so updates never collide.
                if (fr_next_angle_ack) begin
                    r_st[w_hand_bank] <= READING;
                    if (r_st[~w_hand_bank] == READING) r_st[~w_hand_bank] <= EMPTY;
                    r_rd_sel   <= w_hand_bank;
                    fr_angle   <= r_angle_reg[w_hand_bank];
                    r_hand_cnt <= r_hand_cnt + CW'(1);
                end
            end
        end
    end

endmodule
